dl_watch_report_ctrl: RTL and testbench

- Downstream consumer of the per-process deadlock detect units' `dl_in_vec` outputs.
- Confirms that a reported deadlock persists, then selects and broadcasts the origin process and drives `dl_detect_out` back to the detect units.
- Collects the set of processes in the dependency cycle and streams that set to the simulation bench over a valid/ready port.
- Finally pulses `token_clear` and latches a sticky fatal flag.

---
 rtl/dl_watch_report_ctrl.sv | 147 ++++++++++++++
 tb/tb_dl_watch_report_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_watch_report_ctrl.sv
// Deadlock watch/report controller: confirms a persistent deadlock report, broadcasts
// the origin process, streams the dependency-cycle members to the bench, then halts.
module dl_watch_report_ctrl #(
   parameter int PROC_NUM       = 4,
   parameter int CONFIRM_CYCLES = 16,
   parameter int IDX_W          = 2,
   parameter int TIME_W         = 32
) (
   input  logic                dl_clock,
   input  logic                dl_reset,
   input  logic [PROC_NUM-1:0] dl_in_vec,
   input  logic                all_finish,
   output logic                dl_detect_out,
   output logic [PROC_NUM-1:0] origin,
   output logic                token_clear,
   output logic                rpt_valid,
   input  logic                rpt_ready,
   output logic [IDX_W-1:0]    rpt_proc,
   output logic                rpt_last,
   output logic [TIME_W-1:0]   detect_time,
   output logic                dl_fatal
);

   localparam int CONF_W  = $clog2(CONFIRM_CYCLES + 1);
   localparam int PHASE_W = $clog2(PROC_NUM + 2);
   localparam logic [CONF_W-1:0]  CONF_LAST  = CONF_W'(CONFIRM_CYCLES - 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PROC_NUM);

   typedef enum logic [2:0] {
      IDLE, CONFIRM, DETECT, REPORT, CLEAR, HALT
   } state_t;

   state_t state, state_next;

   logic [TIME_W-1:0]   time_cnt;
   logic [CONF_W-1:0]   conf_cnt;
   logic [PHASE_W-1:0]  phase_cnt;
   logic [IDX_W-1:0]    cand;
   logic [PROC_NUM-1:0] member_mask;
   logic [PROC_NUM-1:0] eff;
   logic [PROC_NUM-1:0] head_bit;
   logic [IDX_W-1:0]    eff_low;
   logic [IDX_W-1:0]    mask_low;
   logic                mask_single;
   logic                cand_live;
   logic                episode_now;
   logic                episode_next;

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
      lowest_idx = '0;
      for (int i = PROC_NUM - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = IDX_W'(i);
      end
   endfunction

   always_comb begin
      eff          = dl_in_vec & ~{PROC_NUM{all_finish}};
      eff_low      = lowest_idx(eff);
      mask_low     = lowest_idx(member_mask);
      head_bit     = PROC_NUM'(1) << mask_low;
      mask_single  = (member_mask != '0) &&
                     ((member_mask & (member_mask - PROC_NUM'(1))) == '0);
      cand_live    = eff[cand];
      episode_now  = (state == DETECT) || (state == REPORT);
      episode_next = (state_next == DETECT) || (state_next == REPORT);
      rpt_valid    = (state == REPORT);
      rpt_proc     = rpt_valid ? mask_low : '0;
      rpt_last     = rpt_valid && mask_single;
      token_clear  = (state == CLEAR);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (eff != '0) state_next = CONFIRM;
         CONFIRM: begin
            if (all_finish || !cand_live) state_next = IDLE;
            else if (conf_cnt == CONF_LAST) state_next = DETECT;
         end
         DETECT: begin
            if (all_finish) state_next = CLEAR;
            else if (phase_cnt == PHASE_LAST) state_next = REPORT;
         end
         REPORT:  if (rpt_ready && mask_single) state_next = CLEAR;
         CLEAR:   state_next = dl_fatal ? HALT : IDLE;
         HALT:    state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge dl_clock or negedge dl_reset) begin
      if (!dl_reset) state <= IDLE;
      else           state <= state_next;
   end

   // dl_detect_out/origin drop on the edge into CLEAR so CLEAR itself shows them low.
   always_ff @(posedge dl_clock or negedge dl_reset) begin
      if (!dl_reset) begin
         time_cnt      <= '0;
         conf_cnt      <= '0;
         phase_cnt     <= '0;
         cand          <= '0;
         member_mask   <= '0;
         detect_time   <= '0;
         dl_fatal      <= 1'b0;
         dl_detect_out <= 1'b0;
         origin        <= '0;
      end else begin
         time_cnt      <= time_cnt + TIME_W'(1);
         dl_detect_out <= episode_now && episode_next;
         origin        <= (episode_now && episode_next) ? (PROC_NUM'(1) << cand) : '0;
         case (state)
            IDLE: begin
               if (eff != '0) begin
                  cand     <= eff_low;
                  conf_cnt <= CONF_W'(1);
               end
            end
            CONFIRM: begin
               if (all_finish || !cand_live) begin
                  conf_cnt <= '0;
               end else if (conf_cnt == CONF_LAST) begin
                  conf_cnt    <= '0;
                  detect_time <= time_cnt;
                  member_mask <= eff;
                  phase_cnt   <= '0;
               end else begin
                  conf_cnt <= conf_cnt + CONF_W'(1);
               end
            end
            DETECT: begin
               phase_cnt <= phase_cnt + PHASE_W'(1);
               if (all_finish) member_mask <= '0;
               else            member_mask <= member_mask | dl_in_vec;
            end
            REPORT: begin
               if (rpt_ready) begin
                  member_mask <= member_mask & ~head_bit;
                  if (mask_single) dl_fatal <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dl_watch_report_ctrl.sv
// Directed testbench for dl_watch_report_ctrl; inputs change and outputs are sampled
// on the falling clock edge, the DUT registers on the rising edge.
module tb_dl_watch_report_ctrl;

   logic       dl_clock = 1'b0;
   logic       dl_reset;
   logic [3:0] dl_in_vec;
   logic       all_finish;
   logic       dl_detect_out;
   logic [3:0] origin;
   logic       token_clear;
   logic       rpt_valid;
   logic       rpt_ready;
   logic [1:0] rpt_proc;
   logic       rpt_last;
   logic [31:0] detect_time;
   logic       dl_fatal;

   int checks = 0;
   int passed = 0;

   dl_watch_report_ctrl #(
      .PROC_NUM(4), .CONFIRM_CYCLES(16), .IDX_W(2), .TIME_W(32)
   ) dut (
      .dl_clock(dl_clock), .dl_reset(dl_reset), .dl_in_vec(dl_in_vec),
      .all_finish(all_finish), .dl_detect_out(dl_detect_out), .origin(origin),
      .token_clear(token_clear), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
      .rpt_proc(rpt_proc), .rpt_last(rpt_last), .detect_time(detect_time),
      .dl_fatal(dl_fatal)
   );

   always #5 dl_clock = ~dl_clock;

   // Returns on a falling edge with reset just released; the next rising edge is E0.
   task automatic do_reset();
      dl_reset   = 1'b0;
      dl_in_vec  = 4'b0000;
      all_finish = 1'b0;
      rpt_ready  = 1'b0;
      repeat (2) @(negedge dl_clock);
      dl_reset = 1'b1;
   endtask

   task automatic test_reset();
      dl_reset   = 1'b0;
      dl_in_vec  = 4'b0000;
      all_finish = 1'b0;
      rpt_ready  = 1'b0;
      @(negedge dl_clock);
      checks++; if (dl_detect_out !== 1'b0) $display("[TB] FAIL reset_detect: got %0b expected 0", dl_detect_out); else passed++;
      checks++; if (origin !== 4'b0000) $display("[TB] FAIL reset_origin: got %b expected 0000", origin); else passed++;
      checks++; if (token_clear !== 1'b0) $display("[TB] FAIL reset_token_clear: got %0b expected 0", token_clear); else passed++;
      checks++; if (rpt_valid !== 1'b0) $display("[TB] FAIL reset_rpt_valid: got %0b expected 0", rpt_valid); else passed++;
      checks++; if (rpt_proc !== 2'd0) $display("[TB] FAIL reset_rpt_proc: got %0d expected 0", rpt_proc); else passed++;
      checks++; if (rpt_last !== 1'b0) $display("[TB] FAIL reset_rpt_last: got %0b expected 0", rpt_last); else passed++;
      checks++; if (detect_time !== 32'd0) $display("[TB] FAIL reset_detect_time: got %0d expected 0", detect_time); else passed++;
      checks++; if (dl_fatal !== 1'b0) $display("[TB] FAIL reset_fatal: got %0b expected 0", dl_fatal); else passed++;
   endtask

   task automatic test_basic();
      int tc    = 0;
      int beats = 0;
      int seen  = 0;
      do_reset();
      dl_in_vec = 4'b0010;
      rpt_ready = 1'b1;
      for (int k = 0; k <= 25; k++) begin
         @(negedge dl_clock);
         if (token_clear) tc++;
         if (rpt_valid && rpt_ready) beats++;
         if (k == 15) begin
            checks++; if (dl_detect_out !== 1'b0) $display("[TB] FAIL basic_early_detect: got %0b expected 0", dl_detect_out); else passed++;
         end
         if (k == 16) begin
            checks++; if (dl_detect_out !== 1'b1) $display("[TB] FAIL basic_detect_rise: got %0b expected 1", dl_detect_out); else passed++;
            checks++; if (origin !== 4'b0010) $display("[TB] FAIL basic_origin: got %b expected 0010", origin); else passed++;
         end
         if (k == 20) begin
            checks++; if (rpt_valid !== 1'b1) $display("[TB] FAIL basic_rpt_valid: got %0b expected 1", rpt_valid); else passed++;
            checks++; if (rpt_proc !== 2'd1) $display("[TB] FAIL basic_rpt_proc: got %0d expected 1", rpt_proc); else passed++;
            checks++; if (rpt_last !== 1'b1) $display("[TB] FAIL basic_rpt_last: got %0b expected 1", rpt_last); else passed++;
         end
         if (k == 19) dl_in_vec = 4'b0000;
      end
      checks++; if (tc != 1) $display("[TB] FAIL basic_token_clear_count: got %0d expected 1", tc); else passed++;
      checks++; if (beats != 1) $display("[TB] FAIL basic_beat_count: got %0d expected 1", beats); else passed++;
      checks++; if (dl_fatal !== 1'b1) $display("[TB] FAIL basic_fatal: got %0b expected 1", dl_fatal); else passed++;
      checks++; if (detect_time !== 32'd15) $display("[TB] FAIL basic_detect_time: got %0d expected 15", detect_time); else passed++;
      checks++; if (dl_detect_out !== 1'b0) $display("[TB] FAIL basic_halt_detect: got %0b expected 0", dl_detect_out); else passed++;
      // A halted controller must ignore fresh reports.
      dl_in_vec = 4'b1111;
      for (int k = 0; k < 20; k++) begin
         @(negedge dl_clock);
         if (dl_detect_out || rpt_valid || token_clear) seen++;
      end
      checks++; if (seen != 0) $display("[TB] FAIL halt_activity: got %0d active cycles expected 0", seen); else passed++;
      checks++; if (dl_fatal !== 1'b1) $display("[TB] FAIL halt_fatal: got %0b expected 1", dl_fatal); else passed++;
   endtask

   task automatic test_glitch();
      int det = 0;
      int tc  = 0;
      do_reset();
      dl_in_vec = 4'b0100;
      rpt_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge dl_clock);
         if (dl_detect_out) det++;
         if (token_clear) tc++;
         if (k == 9) dl_in_vec = 4'b0000;
      end
      checks++; if (det != 0) $display("[TB] FAIL glitch_detect: got %0d cycles expected 0", det); else passed++;
      checks++; if (tc != 0) $display("[TB] FAIL glitch_token_clear: got %0d expected 0", tc); else passed++;
      checks++; if (dl_fatal !== 1'b0) $display("[TB] FAIL glitch_fatal: got %0b expected 0", dl_fatal); else passed++;
      dl_in_vec = 4'b0001;
      for (int k = 0; k <= 16; k++) begin
         @(negedge dl_clock);
         if (k == 15) begin
            checks++; if (dl_detect_out !== 1'b0) $display("[TB] FAIL glitch_idle_early: got %0b expected 0", dl_detect_out); else passed++;
         end
         if (k == 16) begin
            checks++; if (origin !== 4'b0001) $display("[TB] FAIL glitch_idle_origin: got %b expected 0001", origin); else passed++;
         end
      end
   endtask

   task automatic test_accumulate();
      int tc    = 0;
      int beats = 0;
      logic [1:0] procs [0:3];
      logic       lasts [0:3];
      do_reset();
      dl_in_vec = 4'b1010;
      rpt_ready = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         @(negedge dl_clock);
         if (token_clear) tc++;
         if (rpt_valid && rpt_ready && beats < 4) begin
            procs[beats] = rpt_proc;
            lasts[beats] = rpt_last;
            beats++;
         end
         if (k == 16) begin
            checks++; if (origin !== 4'b0010) $display("[TB] FAIL accum_origin: got %b expected 0010", origin); else passed++;
            dl_in_vec = 4'b0010;
         end
         if (k == 20) dl_in_vec = 4'b0000;
      end
      checks++; if (beats != 2) $display("[TB] FAIL accum_beat_count: got %0d expected 2", beats); else passed++;
      if (beats == 2) begin
         checks++; if (procs[0] !== 2'd1 || lasts[0] !== 1'b0) $display("[TB] FAIL accum_beat0: got proc %0d last %0b expected proc 1 last 0", procs[0], lasts[0]); else passed++;
         checks++; if (procs[1] !== 2'd3 || lasts[1] !== 1'b1) $display("[TB] FAIL accum_beat1: got proc %0d last %0b expected proc 3 last 1", procs[1], lasts[1]); else passed++;
      end
      checks++; if (tc != 1) $display("[TB] FAIL accum_token_clear: got %0d expected 1", tc); else passed++;
      checks++; if (dl_fatal !== 1'b1) $display("[TB] FAIL accum_fatal: got %0b expected 1", dl_fatal); else passed++;
   endtask

   task automatic test_back_to_back_backpressure();
      int w = 0;
      logic [1:0] exp_proc [0:2];
      exp_proc[0] = 2'd1;
      exp_proc[1] = 2'd2;
      exp_proc[2] = 2'd3;
      do_reset();
      dl_in_vec = 4'b0010;
      rpt_ready = 1'b0;
      repeat (17) @(negedge dl_clock);
      dl_in_vec = 4'b1100;
      @(negedge dl_clock);
      dl_in_vec = 4'b0000;
      while (!rpt_valid && w < 10) begin
         @(negedge dl_clock);
         w++;
      end
      checks++; if (rpt_valid !== 1'b1) $display("[TB] FAIL bp_report_start: got %0b expected 1 within 10 cycles", rpt_valid); else passed++;
      for (int b = 0; b < 3; b++) begin
         int bad = 0;
         for (int r = 0; r < 5; r++) begin
            if (rpt_valid !== 1'b1 || rpt_proc !== exp_proc[b] || rpt_last !== (b == 2)) bad++;
            @(negedge dl_clock);
         end
         checks++; if (bad != 0) $display("[TB] FAIL bp_hold_beat%0d: got %0d unstable cycles expected 0", b, bad); else passed++;
         checks++; if (rpt_proc !== exp_proc[b]) $display("[TB] FAIL bp_proc_beat%0d: got %0d expected %0d", b, rpt_proc, exp_proc[b]); else passed++;
         rpt_ready = 1'b1;
         @(negedge dl_clock);
         rpt_ready = 1'b0;
      end
      checks++; if (token_clear !== 1'b1) $display("[TB] FAIL bp_token_clear: got %0b expected 1", token_clear); else passed++;
      @(negedge dl_clock);
      checks++; if (token_clear !== 1'b0) $display("[TB] FAIL bp_token_pulse: got %0b expected 0", token_clear); else passed++;
      checks++; if (dl_fatal !== 1'b1) $display("[TB] FAIL bp_fatal: got %0b expected 1", dl_fatal); else passed++;
   endtask

   task automatic test_all_finish();
      int det = 0;
      int tc  = 0;
      int rv  = 0;
      do_reset();
      dl_in_vec = 4'b0001;
      rpt_ready = 1'b1;
      for (int k = 0; k <= 28; k++) begin
         @(negedge dl_clock);
         if (k <= 24 && dl_detect_out) det++;
         if (k <= 26 && token_clear) tc++;
         if (rpt_valid) rv++;
         if (k == 25) begin
            checks++; if (dl_detect_out !== 1'b1) $display("[TB] FAIL af_redetect: got %0b expected 1", dl_detect_out); else passed++;
            checks++; if (origin !== 4'b0001) $display("[TB] FAIL af_origin: got %b expected 0001", origin); else passed++;
         end
         if (k == 27) begin
            checks++; if (token_clear !== 1'b1) $display("[TB] FAIL af_detect_clear: got %0b expected 1", token_clear); else passed++;
            checks++; if (dl_detect_out !== 1'b0) $display("[TB] FAIL af_clear_detect: got %0b expected 0", dl_detect_out); else passed++;
         end
         if (k == 28) begin
            checks++; if (dl_fatal !== 1'b0) $display("[TB] FAIL af_fatal: got %0b expected 0", dl_fatal); else passed++;
            checks++; if (token_clear !== 1'b0) $display("[TB] FAIL af_token_pulse: got %0b expected 0", token_clear); else passed++;
         end
         if (k == 7)  all_finish = 1'b1;
         if (k == 8)  all_finish = 1'b0;
         if (k == 26) all_finish = 1'b1;
      end
      all_finish = 1'b0;
      dl_in_vec  = 4'b0000;
      checks++; if (det != 0) $display("[TB] FAIL af_confirm_abort: got %0d detect cycles expected 0", det); else passed++;
      checks++; if (tc != 0) $display("[TB] FAIL af_confirm_token: got %0d expected 0", tc); else passed++;
      checks++; if (rv != 0) $display("[TB] FAIL af_no_report: got %0d valid cycles expected 0", rv); else passed++;
   endtask

   task automatic test_reset_mid_report();
      do_reset();
      dl_in_vec = 4'b0011;
      rpt_ready = 1'b0;
      repeat (21) @(negedge dl_clock);
      checks++; if (rpt_valid !== 1'b1) $display("[TB] FAIL mid_in_report: got %0b expected 1", rpt_valid); else passed++;
      #2 dl_reset = 1'b0;
      #1;
      checks++; if (dl_detect_out !== 1'b0 || origin !== 4'b0000) $display("[TB] FAIL mid_reset_detect: got %0b/%b expected 0/0000", dl_detect_out, origin); else passed++;
      checks++; if (rpt_valid !== 1'b0 || rpt_proc !== 2'd0 || rpt_last !== 1'b0) $display("[TB] FAIL mid_reset_rpt: got %0b/%0d/%0b expected 0/0/0", rpt_valid, rpt_proc, rpt_last); else passed++;
      checks++; if (detect_time !== 32'd0 || dl_fatal !== 1'b0 || token_clear !== 1'b0) $display("[TB] FAIL mid_reset_misc: got %0d/%0b/%0b expected 0/0/0", detect_time, dl_fatal, token_clear); else passed++;
      @(negedge dl_clock);
      dl_reset  = 1'b1;
      rpt_ready = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         @(negedge dl_clock);
         if (k == 15) begin
            checks++; if (dl_detect_out !== 1'b0) $display("[TB] FAIL mid_reconfirm_early: got %0b expected 0", dl_detect_out); else passed++;
         end
         if (k == 16) begin
            checks++; if (dl_detect_out !== 1'b1 || origin !== 4'b0001) $display("[TB] FAIL mid_reconfirm: got %0b/%b expected 1/0001", dl_detect_out, origin); else passed++;
            checks++; if (detect_time !== 32'd15) $display("[TB] FAIL mid_detect_time: got %0d expected 15", detect_time); else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_accumulate();
      test_back_to_back_backpressure();
      test_all_finish();
      test_reset_mid_report();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
